// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: start detection, mid-bit majority sampling,
// LSB-first deserialization with parity/stop checking and one-cycle result pulses.
module uart_rx_frame_ctrl #(
  parameter int data_width     = 8,
  parameter int prescale_width = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      RX_IN,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [prescale_width-1:0] prescale,
  input  logic [prescale_width-1:0] edge_cnt,
  input  logic [3:0]                bit_cnt,
  output logic                      edge_bit_counter_enable,
  output logic [data_width-1:0]     P_DATA,
  output logic                      data_valid,
  output logic                      par_err,
  output logic                      stp_err,
  output logic                      strt_glitch
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [3:0] last_data_idx = 4'(data_width);

  state_t                    state, state_n;
  logic                      par_en_q, par_typ_q;
  logic [prescale_width-1:0] half_q;
  logic                      samp0, samp1;
  logic [data_width-1:0]     shreg;
  logic                      par_flag;

  logic decide, bit_val;
  logic start_frame, shift_en, par_chk, stop_dec, glitch_n;

  always_comb begin
    decide  = (edge_cnt == half_q + prescale_width'(1));
    bit_val = (samp0 & samp1) | (samp0 & RX_IN) | (samp1 & RX_IN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n     = state;
    start_frame = 1'b0;
    shift_en    = 1'b0;
    par_chk     = 1'b0;
    stop_dec    = 1'b0;
    glitch_n    = 1'b0;
    case (state)
      IDLE: begin
        if (!RX_IN) begin
          state_n     = START;
          start_frame = 1'b1;
        end
      end
      START: begin
        if (decide) begin
          if (bit_val) begin
            state_n  = IDLE;
            glitch_n = 1'b1;
          end else begin
            state_n  = DATA;
          end
        end
      end
      DATA: begin
        if (decide) begin
          shift_en = 1'b1;
          if (bit_cnt == last_data_idx) state_n = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (decide) begin
          par_chk = 1'b1;
          state_n = STOP;
        end
      end
      STOP: begin
        if (decide) begin
          stop_dec = 1'b1;
          state_n  = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    edge_bit_counter_enable = (state == START) || (state == DATA) ||
                              (state == PARITY) || (state == STOP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_en_q    <= 1'b0;
      par_typ_q   <= 1'b0;
      half_q      <= '0;
      samp0       <= 1'b0;
      samp1       <= 1'b0;
      shreg       <= '0;
      par_flag    <= 1'b0;
      P_DATA      <= '0;
      data_valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      strt_glitch <= 1'b0;
    end else begin
      strt_glitch <= glitch_n;
      data_valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      if (edge_cnt == half_q - prescale_width'(1)) samp0 <= RX_IN;
      if (edge_cnt == half_q)                      samp1 <= RX_IN;
      if (start_frame) begin
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        half_q    <= prescale >> 1;
        par_flag  <= 1'b0;
      end
      if (shift_en) shreg <= {bit_val, shreg[data_width-1:1]};
      if (par_chk)  par_flag <= bit_val ^ (^shreg) ^ par_typ_q;
      // Results load on the stop decision so they are visible exactly during DONE.
      if (stop_dec) begin
        P_DATA     <= shreg;
        data_valid <= bit_val & ~par_flag;
        par_err    <= par_flag;
        stp_err    <= ~bit_val;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl: directed frames plus randomized
// frames, checked against frame-level expectations computed from the bit contents.
module tb_uart_rx_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       RX_IN;
  logic       PAR_EN, PAR_TYP;
  logic [5:0] prescale;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       edge_bit_counter_enable;
  logic [7:0] P_DATA;
  logic       data_valid, par_err, stp_err, strt_glitch;

  int checks = 0;
  int errors = 0;

  uart_rx_frame_ctrl #(.data_width(8), .prescale_width(6)) dut (
    .clk(clk), .rst(rst), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .prescale(prescale), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
    .edge_bit_counter_enable(edge_bit_counter_enable), .P_DATA(P_DATA),
    .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err),
    .strt_glitch(strt_glitch)
  );

  always #5 clk = ~clk;

  // Upstream edge/bit counter behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (!edge_bit_counter_enable) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (edge_cnt == prescale) begin
      edge_cnt <= 6'd1;
      bit_cnt  <= bit_cnt + 4'd1;
    end else begin
      edge_cnt <= edge_cnt + 6'd1;
    end
  end

  // Output monitor, sampled on the falling edge.
  int n_dv = 0, n_pe = 0, n_se = 0, n_sg = 0;
  int en_viol = 0, hold_viol = 0, width_viol = 0;
  int run = 0, last_run = 0;
  logic [7:0] last_pdata = '0, prev_pdata = '0;
  logic prev_en = 0, prev_dv = 0, prev_pe = 0, prev_se = 0, prev_sg = 0;
  logic [7:0] dv_data[$];

  always @(negedge clk) begin
    logic pulse;
    if (rst) begin
      prev_en = 0; prev_dv = 0; prev_pe = 0; prev_se = 0; prev_sg = 0;
      prev_pdata = P_DATA;
      run = 0;
    end else begin
      pulse = data_valid | par_err | stp_err;
      if (data_valid) begin n_dv++; dv_data.push_back(P_DATA); end
      if (par_err) n_pe++;
      if (stp_err) n_se++;
      if (strt_glitch) n_sg++;
      if (pulse) begin
        last_pdata = P_DATA;
        if (edge_bit_counter_enable !== 1'b0 || prev_en !== 1'b1) en_viol++;
      end
      if (P_DATA !== prev_pdata && !pulse) hold_viol++;
      if ((data_valid && prev_dv) || (par_err && prev_pe) ||
          (stp_err && prev_se) || (strt_glitch && prev_sg)) width_viol++;
      if (edge_bit_counter_enable) run++;
      else begin
        if (prev_en) last_run = run;
        run = 0;
      end
      prev_en = edge_bit_counter_enable; prev_pdata = P_DATA;
      prev_dv = data_valid; prev_pe = par_err; prev_se = stp_err; prev_sg = strt_glitch;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    tick(n);
  endtask

  // One bit period; with noise, one of the three mid-bit sample cycles is inverted.
  task automatic drive_bit(input int p, input logic b, input bit noise);
    int j;
    j = noise ? int'($urandom_range(2)) : -100;
    for (int c = 0; c < p; c++) begin
      RX_IN = (c == p / 2 + j) ? ~b : b;
      tick(1);
    end
  endtask

  task automatic send_frame(input int p, input logic [7:0] d, input logic pen,
                            input logic ptyp, input logic pbit, input logic stopb,
                            input bit noise);
    PAR_EN = pen; PAR_TYP = ptyp; prescale = 6'(p);
    drive_bit(p, 1'b0, noise);
    for (int i = 0; i < 8; i++) drive_bit(p, d[i], noise);
    if (pen) drive_bit(p, pbit, noise);
    drive_bit(p, stopb, noise);
  endtask

  // Sends one frame followed by idle and checks the pulses it should have produced.
  task automatic frame_test(input string tag, input int p, input logic [7:0] d,
                            input logic pen, input logic ptyp, input logic pbit,
                            input logic stopb, input bit noise);
    int s_dv, s_pe, s_se, s_sg, s_ev, s_hv, s_wv;
    logic par_bad, stp_bad, dv_exp, sg_exp;
    int stop_idx;
    s_dv = n_dv; s_pe = n_pe; s_se = n_se; s_sg = n_sg;
    s_ev = en_viol; s_hv = hold_viol; s_wv = width_viol;
    send_frame(p, d, pen, ptyp, pbit, stopb, noise);
    idle(3 * p + 10);
    par_bad  = pen && (pbit != ((^d) ^ ptyp));
    stp_bad  = !stopb;
    dv_exp   = !par_bad && !stp_bad;
    // A low stop bit re-arms start detection; with prescale >= 16 that happens
    // while the line is still low, and the idle line then reads as a glitch.
    sg_exp   = stp_bad && (p / 2 + 4 < p);
    stop_idx = pen ? 10 : 9;
    check({tag, "_dv"},  32'(n_dv - s_dv), 32'(dv_exp));
    check({tag, "_pe"},  32'(n_pe - s_pe), 32'(par_bad));
    check({tag, "_se"},  32'(n_se - s_se), 32'(stp_bad));
    check({tag, "_sg"},  32'(n_sg - s_sg), 32'(sg_exp));
    check({tag, "_pdata"}, 32'(last_pdata), 32'(d));
    if (dv_exp) check({tag, "_dvdata"}, 32'(dv_data[dv_data.size() - 1]), 32'(d));
    if (!stp_bad) check({tag, "_enrun"}, 32'(last_run), 32'(stop_idx * p + p / 2 + 2));
    check({tag, "_enviol"},   32'(en_viol - s_ev),    32'd0);
    check({tag, "_hold"},     32'(hold_viol - s_hv),  32'd0);
    check({tag, "_width"},    32'(width_viol - s_wv), 32'd0);
  endtask

  initial begin
    int s_dv, s_pe, s_se, s_sg, s_q;
    rst = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0; prescale = 6'd8;
    tick(3);
    check("rst_en",  32'(edge_bit_counter_enable), 32'd0);
    check("rst_out", {20'd0, P_DATA, data_valid, par_err, stp_err, strt_glitch}, 32'd0);
    rst = 1'b0;
    idle(5);

    frame_test("even_a5", 8, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    s_dv = n_dv; s_q = dv_data.size();
    send_frame(16, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(16, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(60);
    check("b2b_cnt", 32'(n_dv - s_dv), 32'd2);
    check("b2b_d0",  32'(dv_data[s_q]), 32'h3C);
    check("b2b_d1",  32'(dv_data[s_q + 1]), 32'hFF);

    frame_test("odd_err", 32, 8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    frame_test("stp_err", 8, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    s_dv = n_dv; s_pe = n_pe; s_se = n_se; s_sg = n_sg;
    prescale = 6'd8;
    RX_IN = 1'b0; tick(2);
    idle(40);
    check("glitch_sg",  32'(n_sg - s_sg), 32'd1);
    check("glitch_oth", 32'((n_dv - s_dv) + (n_pe - s_pe) + (n_se - s_se)), 32'd0);
    check("glitch_run", 32'(last_run), 32'd6);
    check("glitch_idle", 32'(edge_bit_counter_enable), 32'd0);

    s_dv = n_dv; s_pe = n_pe; s_se = n_se; s_sg = n_sg;
    PAR_EN = 1'b1; PAR_TYP = 1'b0; prescale = 6'd16;
    drive_bit(16, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(16, i[0], 1'b0);
    RX_IN = 1'b0; tick(8);
    rst = 1'b1; #1;
    check("mid_rst_en",  32'(edge_bit_counter_enable), 32'd0);
    check("mid_rst_out", {20'd0, P_DATA, data_valid, par_err, stp_err, strt_glitch}, 32'd0);
    tick(2);
    rst = 1'b0;
    idle(80);
    check("mid_rst_quiet",
          32'((n_dv - s_dv) + (n_pe - s_pe) + (n_se - s_se) + (n_sg - s_sg)), 32'd0);

    frame_test("clean_96", 16, 8'h96, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    frame_test("noise_96", 16, 8'h96, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

    for (int n = 0; n < 16; n++) begin
      int p;
      logic [7:0] d;
      logic pen, ptyp, pbit, stopb;
      p     = 8 << $urandom_range(2);
      d     = 8'($urandom);
      pen   = 1'($urandom);
      ptyp  = 1'($urandom);
      pbit  = (^d) ^ ptyp ^ ($urandom_range(3) == 0);
      stopb = ($urandom_range(4) != 0);
      frame_test($sformatf("rnd%0d", n), p, d, pen, ptyp, pbit, stopb, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
